// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : leaf_out_arbiter                                           |
// | Description : Shares the leaf-to-BFT packet channel between the user     |
// |               output streams. Picks one eligible stream per cycle,       |
// |               stamps dest leaf/port and rolling address, and gates       |
// |               each stream on per-port credits.                           |
// |               Build option: LEAF_ARB_FIXED_PRIO_EN selects fixed         |
// |               priority (lowest index wins) instead of round robin.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module leaf_out_arbiter #(
    parameter int NUM_OUT_PORTS         = 7,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PACKET_BITS           = 49,
    parameter int CREDIT_INIT           = 128,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
    output logic [PACKET_BITS-1:0]                 pkt_out,
    input  logic                                   pkt_rdy,
    input  logic                                   credit_upd,
    input  logic [NUM_PORT_BITS-1:0]               credit_upd_port,
    input  logic                                   cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]               cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS:0]   cfg_data
);

    // Credit counter is one bit wider than the address so a full window fits.
    localparam int c_CW   = NUM_ADDR_BITS + 1;
    localparam int c_BODY = NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam logic [c_CW:0]            c_CRED_MAX  = {1'b0, {c_CW{1'b1}}};
    localparam logic [c_CW:0]            c_FREE      = (c_CW+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [c_CW-1:0]          c_CRED_INIT = c_CW'(CREDIT_INIT);
    localparam logic [NUM_PORT_BITS-1:0] c_LAST_INIT = NUM_PORT_BITS'(NUM_OUT_PORTS - 1);

    logic [PACKET_BITS-1:0]   r_pkt;
    logic [NUM_OUT_PORTS-1:0] w_elig;
    logic [NUM_OUT_PORTS-1:0] w_gnt_oh;
    logic [NUM_OUT_PORTS-1:0] w_take;
    logic [c_BODY-1:0]        w_cand [NUM_OUT_PORTS];
    logic [c_BODY-1:0]        w_sel;
    logic                     w_load;
    logic                     w_any;

`ifndef LEAF_ARB_FIXED_PRIO_EN
    logic [NUM_PORT_BITS-1:0] r_last;
    logic [NUM_PORT_BITS-1:0] w_gnt_idx;
    logic [NUM_OUT_PORTS-1:0] w_hi;
`endif

    // The output register can accept a new word when empty or being drained.
    assign w_load = ~r_pkt[PACKET_BITS-1] | pkt_rdy;
    assign w_take = w_load ? w_gnt_oh : '0;
    assign w_any  = |w_take;

    assign ack_interface2user = w_take;
    assign pkt_out            = r_pkt;

    // Per-port configuration, rolling address and credit state.
    for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
        logic                     r_en;
        logic [NUM_LEAF_BITS-1:0] r_leaf;
        logic [NUM_PORT_BITS-1:0] r_dport;
        logic [NUM_ADDR_BITS-1:0] r_addr;
        logic [c_CW-1:0]          r_credit;
        logic                     w_cfg_hit;
        logic                     w_upd_hit;
        logic [c_CW:0]            w_sum;

        // Out-of-range port indices never match any port, so they are ignored.
        assign w_cfg_hit = cfg_wr && (cfg_port == NUM_PORT_BITS'(gi));
        assign w_upd_hit = credit_upd && (credit_upd_port == NUM_PORT_BITS'(gi));

        // Return and consumption may land together; saturate the combined result.
        assign w_sum = {1'b0, r_credit} + (w_upd_hit ? c_FREE : '0)
                     - {{c_CW{1'b0}}, w_take[gi]};

        assign w_elig[gi] = vld_user2interface[gi] & r_en & (r_credit != '0);
        assign w_cand[gi] = {r_leaf, r_dport, r_addr,
                             din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]};

`ifndef LEAF_ARB_FIXED_PRIO_EN
        // Ports above the last grant are searched first.
        assign w_hi[gi] = (NUM_PORT_BITS'(gi) > r_last);
`endif

        // Port state update: config write, address roll and credit accounting.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_en     <= 1'b0;
                r_leaf   <= '0;
                r_dport  <= '0;
                r_addr   <= '0;
                r_credit <= c_CRED_INIT;
            end else begin
                if (w_cfg_hit) begin
                    {r_en, r_leaf, r_dport} <= cfg_data;
                end
                if (w_take[gi]) begin
                    r_addr <= r_addr + NUM_ADDR_BITS'(1);
                end
                if (w_take[gi] || w_upd_hit) begin
                    r_credit <= (w_sum > c_CRED_MAX) ? c_CRED_MAX[c_CW-1:0] : w_sum[c_CW-1:0];
                end
            end
        end
    end

`ifndef LEAF_ARB_FIXED_PRIO_EN
    // Round robin: first eligible above the last grant, else lowest eligible.
    always_comb begin
        logic v_found;
        v_found   = 1'b0;
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (!v_found && w_elig[i] && w_hi[i]) begin
                v_found     = 1'b1;
                w_gnt_oh[i] = 1'b1;
                w_gnt_idx   = NUM_PORT_BITS'(i);
            end
        end
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (!v_found && w_elig[i]) begin
                v_found     = 1'b1;
                w_gnt_oh[i] = 1'b1;
                w_gnt_idx   = NUM_PORT_BITS'(i);
            end
        end
    end

    // Pointer moves only when a grant is actually taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= c_LAST_INIT;
        end else if (w_any) begin
            r_last <= w_gnt_idx;
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        logic v_found;
        v_found  = 1'b0;
        w_gnt_oh = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (!v_found && w_elig[i]) begin
                v_found     = 1'b1;
                w_gnt_oh[i] = 1'b1;
            end
        end
    end
`endif

    // One-hot mux of the granted port's header and payload.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel = w_cand[i];
            end
        end
    end

    // Output register: load on grant, drop valid when loading with nothing eligible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_pkt <= {1'b1, w_sel};
            end else begin
                r_pkt[PACKET_BITS-1] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_leaf_out_arbiter                                        |
// | Description : Randomized self-checking bench for leaf_out_arbiter with   |
// |               a behavioural reference model of the arbitration rules.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_leaf_out_arbiter;

    localparam int N  = 7;
    localparam int PB = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*PB-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic [48:0]     pkt_out;
    logic            pkt_rdy;
    logic            cupd;
    logic [3:0]      cupd_port;
    logic            cfg_wr;
    logic [3:0]      cfg_port;
    logic [9:0]      cfg_data;

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .pkt_out                 (pkt_out),
        .pkt_rdy                 (pkt_rdy),
        .credit_upd              (cupd),
        .credit_upd_port         (cupd_port),
        .cfg_wr                  (cfg_wr),
        .cfg_port                (cfg_port),
        .cfg_data                (cfg_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_en   [N];
    int          m_leaf [N];
    int          m_port [N];
    int          m_addr [N];
    int          m_cred [N];
    int          m_last;
    logic [48:0] m_pkt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i]   = 0;
            m_leaf[i] = 0;
            m_port[i] = 0;
            m_addr[i] = 0;
            m_cred[i] = 128;
        end
        m_last = N - 1;
        m_pkt  = '0;
    endfunction

    // Winner among ports that want to send, are enabled and hold credit.
    function automatic int pick();
        int idx;
        for (int k = 0; k < N; k++) begin
`ifdef LEAF_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_last + 1 + k) % N;
`endif
            if (vld[idx] && m_en[idx] != 0 && m_cred[idx] > 0) return idx;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs already driven; ends at next posedge+1.
    task automatic step();
        logic [N-1:0] e_ack;
        bit           load;
        int           g;
        int           p;
        #2;
        load  = !m_pkt[48] || pkt_rdy;
        g     = load ? pick() : -1;
        e_ack = '0;
        if (g >= 0) e_ack[g] = 1'b1;
        chk("ack", {57'd0, ack}, {57'd0, e_ack});
        if (load) begin
            if (g >= 0) begin
                m_pkt = {1'b1, 5'(m_leaf[g]), 4'(m_port[g]), 7'(m_addr[g]), din[g*PB +: PB]};
                m_addr[g] = (m_addr[g] + 1) % 128;
                m_cred[g] = m_cred[g] - 1;
                m_last    = g;
            end else begin
                m_pkt[48] = 1'b0;
            end
        end
        p = int'(cupd_port);
        if (cupd && p < N) begin
            m_cred[p] = m_cred[p] + 64;
            if (m_cred[p] > 255) m_cred[p] = 255;
        end
        p = int'(cfg_port);
        if (cfg_wr && p < N) begin
            m_en[p]   = int'(cfg_data[9]);
            m_leaf[p] = int'(cfg_data[8:4]);
            m_port[p] = int'(cfg_data[3:0]);
        end
        @(posedge clk);
        #1;
        chk("pkt", {15'd0, pkt_out}, {15'd0, m_pkt});
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom;
    endtask

    task automatic rand_inputs(input bit allow_credit);
        rand_din();
        vld       = N'($urandom | $urandom);
        pkt_rdy   = ($urandom_range(0, 9) < 8);
        cupd      = allow_credit && ($urandom_range(0, 11) == 0);
        cupd_port = 4'($urandom_range(0, 15));
        cfg_wr    = ($urandom_range(0, 49) == 0);
        cfg_port  = 4'($urandom_range(0, 15));
        cfg_data  = {($urandom_range(0, 4) != 0), 5'($urandom), 4'($urandom)};
    endtask

    initial begin
        reset     = 1'b0;
        din       = '0;
        vld       = '1;
        pkt_rdy   = 1'b0;
        cupd      = 1'b0;
        cupd_port = '0;
        cfg_wr    = 1'b0;
        cfg_port  = '0;
        cfg_data  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt", {15'd0, pkt_out}, 64'd0);
        chk("rst_ack", {57'd0, ack}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single stream: leaf 3, port 2, fixed payload, address counts up.
        vld      = '0;
        cfg_wr   = 1'b1;
        cfg_port = 4'd0;
        cfg_data = {1'b1, 5'd3, 4'd2};
        step();
        cfg_wr  = 1'b0;
        vld     = 7'b0000001;
        din[31:0] = 32'hA5A5A5A5;
        pkt_rdy = 1'b1;
        repeat (5) step();
        chk("dir_addr", {57'd0, pkt_out[38:32]}, 64'd4);
        chk("dir_leaf", {59'd0, pkt_out[47:43]}, 64'd3);
        chk("dir_pay",  {32'd0, pkt_out[31:0]}, 64'hA5A5A5A5);

        // Enable every port, then contend with all valid.
        for (int i = 0; i < N; i++) begin
            cfg_wr   = 1'b1;
            cfg_port = 4'(i);
            cfg_data = {1'b1, 5'(i + 8), 4'(6 - i)};
            step();
        end
        cfg_wr = 1'b0;
        vld    = '1;
        for (int c = 0; c < 14; c++) begin
            rand_din();
            step();
        end
        pkt_rdy = 1'b0;
        repeat (4) step();
        pkt_rdy = 1'b1;
        repeat (3) step();

        // Random traffic without credit return, then with returns.
        for (int c = 0; c < 1500; c++) begin
            rand_inputs(1'b0);
            step();
        end
        for (int c = 0; c < 1500; c++) begin
            rand_inputs(1'b1);
            step();
        end

        // Asynchronous reset while a packet is held.
        cfg_wr    = 1'b1;
        cfg_port  = 4'd0;
        cfg_data  = {1'b1, 5'd1, 4'd1};
        cupd      = 1'b1;
        cupd_port = 4'd0;
        vld       = '0;
        pkt_rdy   = 1'b1;
        step();
        cfg_wr  = 1'b0;
        cupd    = 1'b0;
        vld     = 7'b0000001;
        step();
        pkt_rdy = 1'b0;
        step();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_pkt", {15'd0, pkt_out}, 64'd0);
        chk("arst_ack", {57'd0, ack}, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        vld     = '1;
        pkt_rdy = 1'b1;
        repeat (4) step();
        for (int c = 0; c < 400; c++) begin
            rand_inputs(1'b1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Shares the single 49-bit leaf-to-BFT packet channel between the NUM_OUT_PORTS user output streams of a leaf shell. Sits between the user kernel's din/vld/ack outputs and the packet egress of the leaf interface. Each cycle it selects one eligible stream and stamps the 32-bit word with the destination leaf, port and rolling address that are configured for that stream. It gates each stream on per-port credits that are returned by the destination.

## Interface
- NUM_OUT_PORTS, 7, number of user output streams (1..15)
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, rolling address field width
- PACKET_BITS, 49, must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- CREDIT_INIT, 128, credits per port after reset
- FREESPACE_UPDATE_SIZE, 64, credits added per credit return pulse

Ports:
- clk  in  1  single clock; all logic in this domain
- reset  in  1  asynchronous, active-low reset
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i at slice i
- vld_user2interface  in  NUM_OUT_PORTS  user word valid per port
- ack_interface2user  out  NUM_OUT_PORTS  word accepted this cycle; one-hot or zero
- pkt_out  out  PACKET_BITS  packet to BFT; bit[48]=valid, [47:43]=leaf, [42:39]=port, [38:32]=addr, [31:0]=payload (field positions given for default parameters)
- pkt_rdy  in  1  BFT side can take pkt_out this cycle
- credit_upd  in  1  credit return pulse
- credit_upd_port  in  NUM_PORT_BITS  local output port index being credited
- cfg_wr  in  1  configuration write strobe
- cfg_port  in  NUM_PORT_BITS  port index written
- cfg_data  in  1+NUM_LEAF_BITS+NUM_PORT_BITS  {enable, dest_leaf, dest_port}

## Operation
- Per port state: cfg_en, dest_leaf, dest_port, addr counter (NUM_ADDR_BITS), credit counter (NUM_ADDR_BITS+1 bits).
- Eligible(i) = vld_user2interface[i] & cfg_en[i] & (credit[i] != 0).
- Load condition: the output register is empty (pkt_out[48]=0) or pkt_rdy=1.
- When the load condition holds and some port is eligible:
  - grant exactly one port g; drive ack_interface2user[g]=1 combinationally in the same cycle;
  - register pkt_out = {1, dest_leaf[g], dest_port[g], addr[g], word g};
  - addr[g] increments and wraps from 2^NUM_ADDR_BITS-1 to 0;
  - credit[g] decrements.
- When the load condition holds and no port is eligible, pkt_out[48] clears at the edge. All other pkt_out bits hold.
- Without load, pkt_out holds its value (stable while valid and not ready). ack stays 0.
- Round robin: a last_grant pointer. The search starts at last_grant+1 modulo NUM_OUT_PORTS. The pointer updates only on a grant.
- Credit update: credit[p] += FREESPACE_UPDATE_SIZE and saturates at 2^(NUM_ADDR_BITS+1)-1.
  - A decrement in the same cycle on the same port applies both changes (net +FREESPACE_UPDATE_SIZE-1).
  - A credit_upd_port value at or above NUM_OUT_PORTS is ignored.
- Config write:
  - updates cfg_en, dest_leaf and dest_port of cfg_port at the edge;
  - takes effect for grants from the next cycle;
  - does not reset addr or credit;
  - a cfg_port value out of range is ignored.
- Disabling a port never drops an already registered packet.

## Timing
- Reset values: pkt_out=0, ack_interface2user=0 (combinational; it is 0 whenever the load condition fails or nothing is eligible), all cfg_en=0, dest fields=0, addr=0, credit=CREDIT_INIT, last_grant=NUM_OUT_PORTS-1 so port 0 wins first.
- Latency: a word accepted at edge k is visible on pkt_out after edge k.
- Throughput: one packet per cycle while pkt_rdy=1.
- Reset asserted mid-operation clears a pending pkt_out immediately (asynchronously). The in-flight word is lost, and its ack was already given.
- Only ack depends on pkt_rdy and vld in the same cycle. No other combinational path exists from any input to any output.

## Configuration
- LEAF_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest eligible index always wins; last_grant is not implemented.
- Not defined: round robin as described above.
- The interface is identical in both builds.

## Test plan
- Reset, then enable port 0 with leaf 3, port 2. Hold vld[0]=1 with word 0xA5A5A5A5 and pkt_rdy=1 → after the next edge pkt_out[48]=1, leaf=3, port=2, addr=0, payload=0xA5A5A5A5; addr counts 1,2,… each cycle.
- Enable all 7 ports and hold all vld=1 with pkt_rdy=1 → grants cycle 0,1,…,6,0. With LEAF_ARB_FIXED_PRIO_EN defined, port 0 wins every cycle.
- Hold pkt_rdy=0 with pkt_out valid → pkt_out is stable, every ack=0, and no addr or credit changes. On release, the next grant proceeds from the saved pointer.
- Send 128 words on port 1 with no credit return → after the 128th word port 1 is never acked. A credit_upd on port 1 gives 64 further acks. A credit_upd in the same cycle as a grant leaves credit at 64+old-1.
- Send 130 words on port 2 with credits replenished → addr wraps 127→0→1.
- Assert reset while pkt_out is valid and pkt_rdy=0 → pkt_out=0 at once. After release, credits=128, addr=0, and every port is disabled (no acks until configured).
